// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and line levels.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_IDX_W     = $clog2(UART_DATA_BITS);

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    UART_IDLE  = 3'd0,
    UART_START = 3'd1,
    UART_DATA  = 3'd2,
    UART_STOP  = 3'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake and serial-side status of the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic                      Tx_Valid;
  logic [UART_DATA_BITS-1:0] Tx_Byte;
  logic                      Tx_Ready;
  logic                      Tx_Serial;
  logic                      Tx_Active;
  logic                      Tx_Done;

  modport master (
    output Tx_Valid, Tx_Byte,
    input  Tx_Ready, Tx_Serial, Tx_Active, Tx_Done
  );

  modport slave (
    input  Tx_Valid, Tx_Byte,
    output Tx_Ready, Tx_Serial, Tx_Active, Tx_Done
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Counts clocks within one serial bit; bit_end marks the last clock of the bit,
// bit_pre_end_c the clock before it (so callers can register last-clock outputs).
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 10417
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear,
  input  logic enable,
  output logic bit_end,
  output logic bit_pre_end_c
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] count;

  assign bit_pre_end_c = enable && (count == PRE_LAST);

  always_ff @(posedge Clk) begin
    if (Rst || clear) begin
      count   <= '0;
      bit_end <= 1'b0;
    end else begin
      bit_end <= bit_pre_end_c;
      if (enable) begin
        count <= (count == LAST) ? '0 : count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register for gapless back-to-back frames.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10417
) (
  input  logic     Clk,
  input  logic     Rst,
  uart_tx_if.slave tx
);

  uart_state_e               state;
  logic [UART_DATA_BITS-1:0] hold;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      hold_full;
  logic [UART_IDX_W-1:0]     bit_index;
  logic [UART_IDX_W-1:0]     next_index_c;
  logic                      bit_end;
  logic                      bit_pre_end_c;
  logic                      accept_c;
  logic                      load_c;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .Clk           (Clk),
    .Rst           (Rst),
    .clear         (state == UART_IDLE),
    .enable        (state != UART_IDLE),
    .bit_end       (bit_end),
    .bit_pre_end_c (bit_pre_end_c)
  );

  assign accept_c     = tx.Tx_Valid && !hold_full;
  assign load_c       = hold_full && ((state == UART_IDLE) || ((state == UART_STOP) && bit_end));
  assign next_index_c = bit_index + UART_IDX_W'(1);
  assign tx.Tx_Ready  = !hold_full;

  // Holding register: an accept and a load never coincide since they need opposite hold_full.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (accept_c) begin
      hold      <= tx.Tx_Byte;
      hold_full <= 1'b1;
    end else if (load_c) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= UART_IDLE;
      shift        <= '0;
      bit_index    <= '0;
      tx.Tx_Serial <= UART_IDLE_LEVEL;
      tx.Tx_Active <= 1'b0;
      tx.Tx_Done   <= 1'b0;
    end else begin
      tx.Tx_Done <= (state == UART_STOP) && bit_pre_end_c;
      case (state)
        UART_IDLE: begin
          bit_index    <= '0;
          tx.Tx_Serial <= UART_IDLE_LEVEL;
          tx.Tx_Active <= 1'b0;
          if (load_c) begin
            shift        <= hold;
            state        <= UART_START;
            tx.Tx_Serial <= UART_START_LEVEL;
            tx.Tx_Active <= 1'b1;
          end
        end
        UART_START: begin
          if (bit_end) begin
            state        <= UART_DATA;
            tx.Tx_Serial <= shift[0];
          end
        end
        UART_DATA: begin
          if (bit_end) begin
            if (bit_index == UART_IDX_W'(UART_DATA_BITS - 1)) begin
              bit_index    <= '0;
              state        <= UART_STOP;
              tx.Tx_Serial <= UART_STOP_LEVEL;
            end else begin
              bit_index    <= next_index_c;
              tx.Tx_Serial <= shift[next_index_c];
            end
          end
        end
        UART_STOP: begin
          // A pending byte starts its start bit on the very next clock.
          if (bit_end) begin
            if (load_c) begin
              shift        <= hold;
              state        <= UART_START;
              tx.Tx_Serial <= UART_START_LEVEL;
            end else begin
              state        <= UART_IDLE;
              tx.Tx_Serial <= UART_IDLE_LEVEL;
              tx.Tx_Active <= 1'b0;
            end
          end
        end
        default: begin
          state        <= UART_IDLE;
          bit_index    <= '0;
          tx.Tx_Serial <= UART_IDLE_LEVEL;
          tx.Tx_Active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-position reference model checked every cycle, plus
// literal waveform checks and a line decoder for the 16-clock loopback instance.
module tb_uart_tx;

  localparam int unsigned C1    = 4;
  localparam int unsigned C2    = 16;
  localparam int unsigned FLEN1 = 10 * C1;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  uart_tx_if tx1();
  uart_tx_if tx2();

  uart_tx #(.CLKS_PER_BIT(C1)) dut    (.Clk(Clk), .Rst(Rst), .tx(tx1));
  uart_tx #(.CLKS_PER_BIT(C2)) dut_lb (.Clk(Clk), .Rst(Rst), .tx(tx2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a frame is 10 bits {stop, data, start}; position counts clocks into it.
  bit         m_busy      = 1'b0;
  int         m_pos       = 0;
  logic [9:0] m_frame     = '1;
  bit         m_hold_full = 1'b0;
  logic [7:0] m_hold      = '0;

  always @(posedge Clk) begin : model
    bit take;
    if (Rst) begin
      m_busy      = 1'b0;
      m_pos       = 0;
      m_hold_full = 1'b0;
    end else begin
      take = (tx1.Tx_Valid === 1'b1) && !m_hold_full;
      if (m_busy) begin
        if (m_pos == FLEN1 - 1) m_busy = 1'b0;
        else m_pos++;
      end
      if (!m_busy && m_hold_full) begin
        m_frame     = {1'b1, m_hold, 1'b0};
        m_busy      = 1'b1;
        m_pos       = 0;
        m_hold_full = 1'b0;
      end
      if (take) begin
        m_hold      = tx1.Tx_Byte;
        m_hold_full = 1'b1;
      end
    end
  end

  bit chk_en = 1'b0;

  always @(negedge Clk) begin : compare
    logic exp_ser, exp_done;
    if (chk_en) begin
      exp_ser  = m_busy ? m_frame[m_pos / C1] : 1'b1;
      exp_done = m_busy && (m_pos == FLEN1 - 1);
      chk("cycle {ser,act,done,rdy}",
          40'({tx1.Tx_Serial, tx1.Tx_Active, tx1.Tx_Done, tx1.Tx_Ready}),
          40'({exp_ser, m_busy, exp_done, !m_hold_full}));
    end
  end

  function automatic logic line(input int sel);
    return (sel != 0) ? tx2.Tx_Serial : tx1.Tx_Serial;
  endfunction

  function automatic logic rdy(input int sel);
    return (sel != 0) ? tx2.Tx_Ready : tx1.Tx_Ready;
  endfunction

  task automatic send(input int sel, input logic [7:0] b, input bit keep);
    int n = 0;
    if (sel != 0) begin tx2.Tx_Valid = 1'b1; tx2.Tx_Byte = b; end
    else          begin tx1.Tx_Valid = 1'b1; tx1.Tx_Byte = b; end
    while (rdy(sel) !== 1'b1 && n < 4000) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 4000) chk("send_timeout", 40'(n), 40'(0));
    @(negedge Clk);
    if (!keep) begin
      if (sel != 0) tx2.Tx_Valid = 1'b0;
      else          tx1.Tx_Valid = 1'b0;
    end
  endtask

  // Mid-bit sampling receiver; expects the line idle when called.
  task automatic rx_frame(input int sel, input int c, output logic [7:0] b, output bit ok);
    int   n = 0;
    logic st, sp;
    b  = '0;
    ok = 1'b0;
    while (line(sel) !== 1'b0 && n < 4000) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 4000) begin
      chk("rx_start_timeout", 40'(n), 40'(0));
      return;
    end
    repeat (c / 2) @(negedge Clk);
    st = line(sel);
    for (int i = 0; i < 8; i++) begin
      repeat (c) @(negedge Clk);
      b[i] = line(sel);
    end
    repeat (c) @(negedge Clk);
    sp = line(sel);
    ok = (st === 1'b0) && (sp === 1'b1);
  endtask

  initial begin : main
    logic [9:0]  exp_a5 = 10'b1101001010;
    logic [39:0] cap, exp_wave;
    logic [7:0]  b;
    bit          ok;
    int          done_at, done_n;
    logic [7:0]  hold_bytes [3] = '{8'h11, 8'h22, 8'h33};

    tx1.Tx_Valid = 1'b0; tx1.Tx_Byte = '0;
    tx2.Tx_Valid = 1'b0; tx2.Tx_Byte = '0;
    repeat (2) @(negedge Clk);
    chk_en = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      chk("idle {ser,rdy,act,done}",
          40'({tx1.Tx_Serial, tx1.Tx_Ready, tx1.Tx_Active, tx1.Tx_Done}), 40'(4'b1100));
    end

    // Single byte 0xA5: literal waveform and done position
    send(0, 8'hA5, 1'b0);
    done_at = -1;
    done_n  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      cap[i]      = tx1.Tx_Serial;
      exp_wave[i] = exp_a5[i / 4];
      if (tx1.Tx_Done === 1'b1) begin
        done_at = i;
        done_n++;
      end
    end
    chk("a5_waveform", cap, exp_wave);
    chk("a5_done_clock", 40'(done_at), 40'(39));
    chk("a5_done_count", 40'(done_n), 40'(1));
    repeat (5) @(negedge Clk);

    // Back-to-back 0x00 then 0xFF: one unbroken 80-clock active run
    fork
      begin
        send(0, 8'h00, 1'b0);
        send(0, 8'hFF, 1'b0);
      end
      begin
        int n = 0;
        int run = 0;
        while (tx1.Tx_Active !== 1'b1 && n < 100) begin @(negedge Clk); n++; end
        while (tx1.Tx_Active === 1'b1 && run < 200) begin @(negedge Clk); run++; end
        chk("b2b_active_run", 40'(run), 40'(80));
      end
    join
    repeat (5) @(negedge Clk);

    // Hold-off: Tx_Valid held high across three bytes
    fork
      begin
        send(0, 8'h11, 1'b1);
        send(0, 8'h22, 1'b1);
        send(0, 8'h33, 1'b0);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          rx_frame(0, C1, b, ok);
          chk("holdoff_byte", 40'(b), 40'(hold_bytes[k]));
          chk("holdoff_framing", 40'(ok), 40'(1));
        end
      end
    join
    repeat (60) @(negedge Clk);
    chk("holdoff_no_extra_frame", 40'(tx1.Tx_Active), 40'(0));

    // Reset during data bit 3 of 0x5A
    send(0, 8'h5A, 1'b0);
    repeat (18) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk("rst_mid {ser,act,rdy}",
        40'({tx1.Tx_Serial, tx1.Tx_Active, tx1.Tx_Ready}), 40'(3'b101));
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (tx1.Tx_Done === 1'b1 || tx1.Tx_Serial !== 1'b1) done_n++;
    end
    chk("rst_mid_quiet", 40'(done_n), 40'(0));
    fork
      send(0, 8'hC3, 1'b0);
      begin
        rx_frame(0, C1, b, ok);
        chk("post_rst_byte", 40'(b), 40'(8'hC3));
        chk("post_rst_framing", 40'(ok), 40'(1));
      end
    join
    repeat (10) @(negedge Clk);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      @(negedge Clk);
      Rst          = ($urandom_range(0, 299) == 0);
      tx1.Tx_Valid = ($urandom_range(0, 2) == 0);
      tx1.Tx_Byte  = 8'($urandom);
    end
    @(negedge Clk);
    Rst = 1'b0;
    tx1.Tx_Valid = 1'b0;
    repeat (100) @(negedge Clk);

    // Loopback at 16 clocks per bit
    fork
      begin
        send(1, 8'h3C, 1'b0);
        send(1, 8'hFF, 1'b0);
      end
      begin
        rx_frame(1, C2, b, ok);
        chk("loop_byte0", 40'(b), 40'(8'h3C));
        chk("loop_framing0", 40'(ok), 40'(1));
        rx_frame(1, C2, b, ok);
        chk("loop_byte1", 40'(b), 40'(8'hFF));
        chk("loop_framing1", 40'(ok), 40'(1));
      end
    join
    repeat (40) @(negedge Clk);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: serialises one byte per frame onto `Tx_Serial` as 8N1 (start bit 0, eight data bits LSB first, one stop bit 1), each bit held for exactly `CLKS_PER_BIT` clocks. It is the transmit-side counterpart of `uart_rx` and shares its bit timing, so a `uart_tx` output wired to a `uart_rx` input with the same parameter is a working link. A one-byte holding register lets the next byte be accepted during the current frame, so back-to-back frames go out with no idle gap.

## Interface
- `CLKS_PER_BIT`, 10417, clocks per serial bit; legal range 2..16383.
- `Clk`  in  1  system clock; all logic on the rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `Tx_Valid`  in  1  `Tx_Byte` is offered this cycle.
- `Tx_Byte`  in  8  byte to transmit; sampled only on an accepting edge.
- `Tx_Ready`  out  1  holding register is empty; combinational `!hold_full`.
- `Tx_Serial`  out  1  serial line, registered; idle level is 1.
- `Tx_Active`  out  1  a frame is being driven (START, DATA or STOP state).
- `Tx_Done`  out  1  one-cycle pulse on the last clock of each stop bit.

## Operation
- **Accept:** a byte is accepted when `Tx_Valid && Tx_Ready` at a rising edge. It is copied into the holding register and `hold_full` is set. While `Tx_Ready` is 0, `Tx_Valid` is ignored; the byte is neither captured nor duplicated.
- **Load:** the shifter loads from the holding register, clearing `hold_full`, in either case:
  - in IDLE with `hold_full` = 1;
  - on the last clock of STOP with `hold_full` = 1.
  
  If an accept and a load fall on the same edge, the new byte is what ends up in the holding register and `hold_full` stays 1.
- **States:** IDLE → START → DATA → STOP → (IDLE or START).
  - IDLE: `Tx_Serial`=1, counter=0, bit index=0.
  - START: `Tx_Serial`=0 for `CLKS_PER_BIT` clocks.
  - DATA: `Tx_Serial`=`shift[bit_index]`. After `CLKS_PER_BIT` clocks, the bit index increments. On index 7, go to STOP and reset the index to 0.
  - STOP: `Tx_Serial`=1 for `CLKS_PER_BIT` clocks. On the last clock, pulse `Tx_Done`. Go to START if a load occurs on that edge, otherwise go to IDLE.
  - Any unused state encoding returns to IDLE.
- **Counter:** `$clog2(CLKS_PER_BIT)` bits (14 at the default). It counts 0..`CLKS_PER_BIT`-1 and clears on wrap. The wrap is the only bit-advance event.
- **Reset** (any state, including mid-frame) takes effect on the next edge:
  - `Tx_Serial`=1, `Tx_Active`=0, `Tx_Done`=0;
  - `hold_full`=0, so `Tx_Ready`=1;
  - counter=0, index=0, state=IDLE.
  
  A partial frame is abandoned and not resumed.

## Timing
- Reset values: `Tx_Serial`=1, `Tx_Ready`=1, `Tx_Active`=0, `Tx_Done`=0.
- Latency: accept at edge N, load and enter START at edge N+1, so `Tx_Serial` is 0 from N+1.
- Frame length: exactly 10·`CLKS_PER_BIT` clocks from the first START clock to the last STOP clock.
- `Tx_Done` is high during the final STOP clock only. `Tx_Active` drops on the following edge unless a back-to-back load occurs.
- Back-to-back: the next start bit begins on the clock immediately after the previous stop bit, with zero idle clocks.
- `Tx_Ready` goes 0 the edge after an accept and returns to 1 the edge the holding register is loaded into the shifter.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding (IDLE/START/DATA/STOP, 3-bit, same values as `uart_rx`);
  - `UART_DATA_BITS`=8;
  - stop-bit and idle line levels.
- One sub-module, `uart_bit_timer`:
  - parameterised by `CLKS_PER_BIT`;
  - inputs `Clk`, `Rst`, `clear`, `enable`;
  - output `bit_end`, a one-cycle pulse at count `CLKS_PER_BIT`-1.
  
  `uart_rx` can later reuse it.

## Test plan
- **Reset, idle:** run 20 clocks after `Rst`, using `CLKS_PER_BIT`=4 for all tests unless noted. Require `Tx_Serial`=1, `Tx_Ready`=1, `Tx_Active`=0, `Tx_Done`=0 throughout.
- **Single byte:** send 0xA5. Require `Tx_Serial` = 0,1,0,1,0,0,1,0,1,1, each level for 4 clocks, starting one edge after the accept. `Tx_Done` pulses once, on clock 40 of the frame.
- **Back-to-back:** accept 0x00, then accept 0xFF during frame 1. Require `Tx_Ready`=0 from the second accept until frame 1's stop ends, and 80 contiguous clocks of two frames with no idle clock between them.
- **Hold-off:** keep `Tx_Valid`=1 with 0x11, 0x22, 0x33 while `Tx_Ready` toggles. Require exactly three frames, in order, with no duplicates.
- **Reset mid-DATA:** assert `Rst` for one clock at bit 3 of 0x5A. Require `Tx_Serial`=1 on the next edge and no `Tx_Done`. A new 0xC3 sent afterwards must frame correctly.
- **Loopback:** connect to `uart_rx` with `CLKS_PER_BIT`=16 and send 0x3C, then 0xFF. Require `Data_Valid` pulses with `Rx_Byte`=0x3C, then 0xFF.
